regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port among NUM_REQ write-back requesters (ALU, load, mult/div).

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write-back arbiter.
//   REG_ADDR_W / REG_DATA_W : register file address and data widths
//   NUM_REGS                : number of architectural registers
//   ZERO_REG                : hard-wired zero register, never written
//   arb_state_e             : lock FSM state (IDLE, LOCKED)
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage : regfile_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: returns a one-hot grant for the
// first asserted valid bit at or after the pointer, wrapping modulo N.
// Ports:
//   valid  in  N      request vector
//   ptr    in  PTR_W  index with highest priority this cycle
//   grant  out N      one-hot grant (all zero when no valid bit is set)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  // Scan from the pointer upwards and stop at the first valid requester.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port among NUM_REQ write-back
// requesters with round-robin arbitration and an optional per-beat lock that
// lets one requester keep the port for a multi-register burst.
// Optional feature macro: REGFILE_WB_SCOREBOARD_EN (pending-write scoreboard).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/lock        per-requester request and keep-grant flag
//   req_addr/data         packed destination/data, requester 0 in the LSBs
//   req_ready             one-hot grant, combinational
//   rf_we/waddr/wdata     registered register-file write port
//   sb_rsv_valid/addr     [SB] mark a destination pending at issue
//   sb_q0/q1_addr, _busy  [SB] hazard query ports
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata
`ifdef REGFILE_WB_SCOREBOARD_EN
  ,
  input  logic                      sb_rsv_valid,
  input  logic [ADDR_W-1:0]         sb_rsv_addr,
  input  logic [ADDR_W-1:0]         sb_q0_addr,
  input  logic [ADDR_W-1:0]         sb_q1_addr,
  output logic                      sb_q0_busy,
  output logic                      sb_q1_busy
`endif
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] elig_s, grant_s;
  logic [PTR_W-1:0]   gidx_s;
  logic               accept_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // While locked only the owner competes; nothing is granted during reset.
  always_comb begin
    if (state_q == LOCKED) begin
      elig_s = req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q);
    end else begin
      elig_s = req_valid;
    end
    elig_s = elig_s & {NUM_REQ{rst_n}};
  end

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .valid (elig_s),
    .ptr   (ptr_q),
    .grant (grant_s)
  );

  assign req_ready = grant_s;
  assign accept_s  = |grant_s;

  // Grant is one-hot, so AND-OR muxing selects the grantee's index and beat.
  always_comb begin
    gidx_s     = '0;
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gidx_s     = gidx_s | (PTR_W'(i) & {PTR_W{grant_s[i]}});
      sel_addr_s = sel_addr_s | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_s[i]}});
      sel_data_s = sel_data_s | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
  end

  // Lock FSM and round-robin pointer next-state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          ptr_d = ptr_inc(gidx_s);
          if (req_lock[gidx_s]) begin
            state_d = LOCKED;
            owner_d = gidx_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        // Owner dropping valid, or a final beat without lock, ends the burst.
        if (!req_valid[owner_q]) begin
          state_d = IDLE;
        end else if (accept_s && !req_lock[owner_q]) begin
          state_d = IDLE;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write-port next values; register 0 completes the handshake but never writes.
  // Address/data follow every accepted beat and hold when nothing is accepted.
  always_comb begin
    rf_we_d = accept_s && (sel_addr_s != ADDR_W'(ZERO_REG));
    if (accept_s) begin
      rf_waddr_d = sel_addr_s;
      rf_wdata_d = sel_data_s;
    end else begin
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end
  end

  // State, pointer and write-port registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] clr_s, set_s;

  // Clear on the write being driven this cycle, then set (set wins); r0 never pending.
  always_comb begin
    clr_s     = rf_we_q ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << rf_waddr_q) : '0;
    set_s     = sb_rsv_valid ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << sb_rsv_addr) : '0;
    pending_d = ((pending_q & ~clr_s) | set_s) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
  end

  // Pending-mask register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A beat being accepted right now also counts as pending for the query.
  assign sb_q0_busy = pending_q[sb_q0_addr] |
                      (accept_s && (sel_addr_s == sb_q0_addr) && (sb_q0_addr != ADDR_W'(ZERO_REG)));
  assign sb_q1_busy = pending_q[sb_q1_addr] |
                      (accept_s && (sel_addr_s == sb_q1_addr) && (sb_q1_addr != ADDR_W'(ZERO_REG)));
`else
  // Without the scoreboard there is no pending state; arbitration is unchanged.
`endif

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Randomised and directed stimulus for regfile_wb_arbiter (NUM_REQ=3).
// A reference model pushes expected grants/busy flags and expected write-port
// values into queues tagged with the cycle they belong to; a negedge monitor
// pops and compares. Honours REGFILE_WB_SCOREBOARD_EN like the design.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [N-1:0]      req_valid, req_lock, req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
`ifdef REGFILE_WB_SCOREBOARD_EN
  logic              sb_rsv_valid;
  logic [AW-1:0]     sb_rsv_addr, sb_q0_addr, sb_q1_addr;
  logic              sb_q0_busy, sb_q1_busy;
`endif

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
`ifdef REGFILE_WB_SCOREBOARD_EN
    ,
    .sb_rsv_valid (sb_rsv_valid),
    .sb_rsv_addr  (sb_rsv_addr),
    .sb_q0_addr   (sb_q0_addr),
    .sb_q1_addr   (sb_q1_addr),
    .sb_q0_busy   (sb_q0_busy),
    .sb_q1_busy   (sb_q1_busy)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; bit [N-1:0] rdy; bit b0; bit b1; } cyc_exp_t;
  typedef struct { int c; bit we; bit [AW-1:0] a; bit [DW-1:0] d; } rf_exp_t;
  cyc_exp_t cq[$];
  rf_exp_t  rq[$];

  // Stimulus for the next step
  bit          s_rst;
  bit [N-1:0]  s_valid, s_lock;
  bit [AW-1:0] s_addr [N];
  bit [DW-1:0] s_data [N];
  bit          s_rsv;
  bit [AW-1:0] s_ra, s_q0, s_q1;

  // Reference model state
  int          m_ptr = 0;
  bit          m_locked = 1'b0;
  int          m_owner = 0;
  bit [31:0]   m_pend = '0;
  bit          m_cur_we = 1'b0;
  bit [AW-1:0] m_cur_a = '0;
  bit [AW-1:0] m_last_a = '0;
  bit [DW-1:0] m_last_d = '0;

  // Register file image written from the DUT write port at negedge
  bit [DW-1:0] rf_mem [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive the stimulus, predict this cycle's grant and next cycle's write.
  task automatic step();
    int       g;
    cyc_exp_t ce;
    rf_exp_t  re;
    bit       new_we;
    @(posedge clk);
    #1;
    rst_n     = s_rst;
    req_valid = s_valid;
    req_lock  = s_lock;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = s_addr[i];
      req_data[i*DW +: DW] = s_data[i];
    end
`ifdef REGFILE_WB_SCOREBOARD_EN
    sb_rsv_valid = s_rsv;
    sb_rsv_addr  = s_ra;
    sb_q0_addr   = s_q0;
    sb_q1_addr   = s_q1;
`endif
    g = -1;
    if (s_rst) begin
      if (m_locked) begin
        if (s_valid[m_owner]) g = m_owner;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (g < 0 && s_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        end
      end
    end
    ce.c   = cyc;
    ce.rdy = (g >= 0) ? N'(1 << g) : '0;
    ce.b0  = m_pend[s_q0] || (g >= 0 && s_q0 != 0 && s_addr[g] == s_q0);
    ce.b1  = m_pend[s_q1] || (g >= 0 && s_q1 != 0 && s_addr[g] == s_q1);
    cq.push_back(ce);

    if (!s_rst) begin
      m_ptr = 0; m_locked = 1'b0; m_owner = 0; m_pend = '0;
      m_last_a = '0; m_last_d = '0; new_we = 1'b0;
    end else begin
      if (m_cur_we) m_pend[m_cur_a] = 1'b0;
      if (s_rsv) m_pend[s_ra] = 1'b1;
      m_pend[0] = 1'b0;
      if (g >= 0) begin
        if (!m_locked) begin
          m_ptr   = (g + 1) % N;
          m_owner = g;
        end
        m_locked = s_lock[g];
        new_we   = (s_addr[g] != 0);
        m_last_a = s_addr[g];
        m_last_d = s_data[g];
      end else begin
        new_we = 1'b0;
        if (m_locked && !s_valid[m_owner]) m_locked = 1'b0;
      end
    end
    m_cur_we = new_we;
    m_cur_a  = m_last_a;
    re.c  = cyc + 1;
    re.we = new_we;
    re.a  = m_last_a;
    re.d  = m_last_d;
    rq.push_back(re);
  endtask

  task automatic idle_stim();
    s_valid = '0; s_lock = '0; s_rsv = 1'b0;
    s_ra = '0; s_q0 = '0; s_q1 = '0;
    for (int i = 0; i < N; i++) begin
      s_addr[i] = AW'(i + 1);
      s_data[i] = $urandom;
    end
  endtask

  // Monitor: compare everything expected for the current cycle.
  always @(negedge clk) begin
    if (rf_we) rf_mem[rf_waddr] = rf_wdata;
    while (cq.size() > 0 && cq[0].c <= cyc) begin
      cyc_exp_t e;
      e = cq.pop_front();
      check("req_ready", 64'(req_ready), 64'(e.rdy));
`ifdef REGFILE_WB_SCOREBOARD_EN
      check("sb_q0_busy", 64'(sb_q0_busy), 64'(e.b0));
      check("sb_q1_busy", 64'(sb_q1_busy), 64'(e.b1));
`endif
    end
    while (rq.size() > 0 && rq[0].c <= cyc) begin
      rf_exp_t r;
      r = rq.pop_front();
      check("rf_we", 64'(rf_we), 64'(r.we));
      check("rf_waddr", 64'(rf_waddr), 64'(r.a));
      check("rf_wdata", 64'(rf_wdata), 64'(r.d));
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_lock = '0; req_addr = '0; req_data = '0;
`ifdef REGFILE_WB_SCOREBOARD_EN
    sb_rsv_valid = 1'b0; sb_rsv_addr = '0; sb_q0_addr = '0; sb_q1_addr = '0;
`endif
    idle_stim();

    // T1: reset held with every requester valid, then release
    s_rst = 1'b0; s_valid = '1;
    repeat (3) step();
    s_rst = 1'b1;
    step();
    idle_stim(); s_valid = 3'b100;
    step();

    // T2: req0/req1 alternate on addresses 3 and 5
    idle_stim(); s_valid = 3'b011; s_addr[0] = 5'd3; s_addr[1] = 5'd5;
    repeat (4) step();
    idle_stim(); s_valid = 3'b001;
    step();

    // T3: req1 locked burst 7,8,9 while req0 waits
    idle_stim(); s_valid = 3'b011; s_lock[1] = 1'b1;
    s_addr[1] = 5'd7; step();
    s_addr[1] = 5'd8; step();
    s_addr[1] = 5'd9; s_lock[1] = 1'b0; step();
    s_valid = 3'b001; step();

    // T4: write to register 0 is accepted but not performed
    idle_stim(); s_valid = 3'b001; s_addr[0] = 5'd0; s_data[0] = 32'hDEADBEEF;
    step();
    idle_stim(); step();

    // T5: reset right after an accept, then grant restarts at req0
    idle_stim(); s_valid = 3'b011; step();
    s_rst = 1'b0; step();
    s_rst = 1'b1; step();
    idle_stim(); step();

`ifdef REGFILE_WB_SCOREBOARD_EN
    // T6: reserve, write-back clear, and same-edge set beats clear
    idle_stim(); s_q0 = 5'd4; s_q1 = 5'd5;
    s_rsv = 1'b1; s_ra = 5'd4; step();
    s_rsv = 1'b0; step();
    s_valid = 3'b001; s_addr[0] = 5'd4; step();
    s_valid = '0; step();
    step();
    step();
    s_valid = 3'b001; step();
    s_valid = '0; s_rsv = 1'b1; step();
    s_rsv = 1'b0; step();
    step();
`endif

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      s_rst   = ($urandom_range(0, 49) != 0);
      s_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        s_lock[i] = ($urandom_range(0, 2) == 0);
        s_addr[i] = AW'($urandom_range(0, 7));
        s_data[i] = $urandom;
      end
      s_rsv = ($urandom_range(0, 2) == 0);
      s_ra  = AW'($urandom_range(0, 7));
      s_q0  = AW'($urandom_range(0, 7));
      s_q1  = AW'($urandom_range(0, 7));
      step();
    end

    s_rst = 1'b1; idle_stim();
    repeat (3) step();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("cycle_queue_drained", 64'(cq.size()), 64'd0);
    check("rf_queue_drained", 64'(rq.size()), 64'd0);
    check("reg0_never_written", 64'(rf_mem[0]), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
